// File: rtl/lfsr_rng_arbiter.sv
// Shares one Fibonacci LFSR between NREQ round-robin requesters, with warm-up after reset/reseed.
// Optional LFSR_STATS_EN adds a wrapping 16-bit count of delivered values (stat_grants).
module lfsr_rng_arbiter #(
    parameter int               WIDTH  = 8,
    parameter int               NREQ   = 4,
    parameter logic [WIDTH-1:0] SEED   = 8'h8A,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter int               WARMUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             busy
`ifdef LFSR_STATS_EN
    ,
    output logic [15:0]      stat_grants
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WARMUP + 1);

    typedef enum logic {WARM, READY} state_t;

    state_t          state;
    logic [WIDTH-1:0] s;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   pick;
    logic            pick_vld;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

    // Round-robin search starts just past the last winner.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= WARM;
            s      <= SEED;
            cnt    <= '0;
            ptr    <= PW'(NREQ - 1);
            gnt    <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            busy   <= 1'b1;
        end else begin
            gnt    <= '0;
            rvalid <= 1'b0;
            if (seed_load) begin
                // All-zero seed would lock the LFSR, so fall back to SEED.
                s     <= (seed_val == '0) ? SEED : seed_val;
                state <= WARM;
                cnt   <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    WARM: begin
                        s <= lfsr_step(s);
                        if (cnt == CW'(WARMUP - 1)) begin
                            state <= READY;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    READY: begin
                        if (pick_vld) begin
                            gnt    <= onehot(pick);
                            rdata  <= s;
                            rvalid <= 1'b1;
                            s      <= lfsr_step(s);
                            ptr    <= pick;
                        end
                    end
                    default: state <= WARM;
                endcase
            end
        end
    end

`ifdef LFSR_STATS_EN
    // Counts values handed out; bumps on the edge that raises rvalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_grants <= '0;
        end else if (seed_load) begin
            stat_grants <= '0;
        end else if (state == READY && pick_vld) begin
            stat_grants <= stat_grants + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Randomized and directed bench for lfsr_rng_arbiter against a cycle-level behavioural model.
module tb_lfsr_rng_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       seed_load;
    logic [7:0] seed_val;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] rdata;
    logic       rvalid;
    logic       busy;
`ifdef LFSR_STATS_EN
    logic [15:0] stat_grants;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    lfsr_rng_arbiter dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_val(seed_val),
        .req(req), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy)
`ifdef LFSR_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: polynomial x^8+x^6+x^5+x^4+1 evaluated over tap positions.
    logic [7:0] m_s, m_rd;
    logic [3:0] m_gnt;
    logic       m_rv, m_busy;
    int         m_warm, m_ptr;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        int taps[4] = '{7, 5, 4, 3};
        int ones = 0;
        foreach (taps[t]) ones += x[taps[t]];
        return 8'((int'(x) * 2) % 256 + (ones % 2));
    endfunction

    task automatic model_reset();
        m_s = 8'h8A; m_warm = 4; m_ptr = 3;
        m_gnt = 0; m_rv = 0; m_rd = 0; m_busy = 1;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic sl, input logic [7:0] sv);
        m_gnt = 0; m_rv = 0;
        if (sl) begin
            m_s = (sv == 0) ? 8'h8A : sv; m_warm = 4; m_busy = 1;
        end else if (m_warm > 0) begin
            m_s = nxt(m_s); m_warm--; m_busy = (m_warm > 0);
        end else if (r != 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_rv == 0 && r[(m_ptr + k) % 4]) begin
                    m_ptr = (m_ptr + k) % 4;
                    m_rv  = 1;
                end
            end
            m_gnt = 4'(1 << m_ptr); m_rd = m_s; m_s = nxt(m_s);
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge(req, seed_load, seed_val);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 0; req = 0; seed_load = 0; seed_val = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 0; req = 0; seed_load = 0; seed_val = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt, rvalid, rdata, busy} !== {4'b0, 1'b0, 8'h00, 1'b1})
            $display("FAIL reset_state: got gnt=%b rv=%b rd=%h busy=%b, want 0000 0 00 1", gnt, rvalid, rdata, busy);
        else n_pass++;
        reset = 1;
        model_reset();
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++;
            if (busy !== (i < 4) || gnt !== 4'b0 || rvalid !== 1'b0)
                $display("FAIL warmup_busy[%0d]: got busy=%b gnt=%b rv=%b, want busy=%b gnt=0000 rv=0", i, busy, gnt, rvalid, (i < 4));
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [7:0] want[2] = '{8'hA5, 8'h4A};
        for (int p = 0; p < 2; p++) begin
            req = 4'b0001; tick(); req = 0;
            n_checks++;
            if (gnt !== 4'b0001 || rvalid !== 1'b1 || rdata !== want[p])
                $display("FAIL single_pulse[%0d]: got gnt=%b rv=%b rd=%h, want 0001 1 %h", p, gnt, rvalid, rdata, want[p]);
            else n_pass++;
            tick();
            n_checks++;
            if (gnt !== 4'b0 || rvalid !== 1'b0 || rdata !== want[p])
                $display("FAIL idle_hold[%0d]: got gnt=%b rv=%b rd=%h, want 0000 0 %h", p, gnt, rvalid, rdata, want[p]);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] want[4] = '{8'hA5, 8'h4A, 8'h95, 8'h2A};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (gnt !== 4'(1 << i) || rdata !== want[i] || rvalid !== 1'b1)
                $display("FAIL round_robin[%0d]: got gnt=%b rd=%h rv=%b, want %b %h 1", i, gnt, rdata, rvalid, 4'(1 << i), want[i]);
            else n_pass++;
        end
        req = 0; tick();
    endtask

    task automatic test_reseed();
        do_reset();
        req = 4'b0101; tick();
        n_checks++;
        if (gnt !== 4'b0001 || rdata !== 8'hA5)
            $display("FAIL reseed_pre: got gnt=%b rd=%h, want 0001 a5", gnt, rdata);
        else n_pass++;
        seed_load = 1; seed_val = 8'h00; tick(); seed_load = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gnt !== 4'b0 || rvalid !== 1'b0 || busy !== (i < 4))
                $display("FAIL reseed_warm[%0d]: got gnt=%b rv=%b busy=%b, want 0000 0 1", i, gnt, rvalid, busy);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || gnt !== 4'b0)
            $display("FAIL reseed_ready: got busy=%b gnt=%b, want 0 0000", busy, gnt);
        else n_pass++;
        tick();
        n_checks++;
        if (gnt !== 4'b0100 || rdata !== 8'hA5 || rvalid !== 1'b1)
            $display("FAIL reseed_grant: got gnt=%b rd=%h rv=%b, want 0100 a5 1", gnt, rdata, rvalid);
        else n_pass++;
        req = 0; tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010; tick();
        n_checks++;
        if (gnt !== 4'b0010 || rvalid !== 1'b1)
            $display("FAIL midgrant_pre: got gnt=%b rv=%b, want 0010 1", gnt, rvalid);
        else n_pass++;
        #2 reset = 0;
        #1;
        n_checks++;
        if ({gnt, rvalid, rdata, busy} !== {4'b0, 1'b0, 8'h00, 1'b1})
            $display("FAIL async_reset: got gnt=%b rv=%b rd=%h busy=%b, want 0000 0 00 1", gnt, rvalid, rdata, busy);
        else n_pass++;
        req = 0;
        @(negedge clk);
        reset = 1;
        model_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++;
            if (busy !== (i < 4) || gnt !== 4'b0)
                $display("FAIL rewarm[%0d]: got busy=%b gnt=%b, want %b 0000", i, busy, gnt, (i < 4));
            else n_pass++;
        end
    endtask

    task automatic test_period();
        int bad = 0;
        do_reset();
        req = 4'b1000;
        for (int n = 1; n <= 256; n++) begin
            tick();
            if (rdata === 8'h00 || gnt !== 4'b1000 || rdata !== m_rd) begin
                if (bad == 0)
                    $display("FAIL period_grant[%0d]: got gnt=%b rd=%h, want 1000 %h (nonzero)", n, gnt, rdata, m_rd);
                bad++;
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;
        n_checks++;
        if (rdata !== 8'hA5)
            $display("FAIL period_wrap: got rd=%h, want a5", rdata);
        else n_pass++;
`ifdef LFSR_STATS_EN
        n_checks++;
        if (stat_grants !== 16'd256)
            $display("FAIL stat_grants: got %0d, want 256", stat_grants);
        else n_pass++;
`endif
        req = 0; tick();
    endtask

    task automatic test_random();
        logic [3:0] prev_req;
        int bad = 0, inv_bad = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req       = 4'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 24) == 0);
            seed_val  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            prev_req  = req;
            tick();
            if ({gnt, rvalid, rdata, busy} !== {m_gnt, m_rv, m_rd, m_busy}) begin
                if (bad < 5)
                    $display("FAIL random[%0d]: got gnt=%b rv=%b rd=%h busy=%b, want %b %b %h %b",
                             c, gnt, rvalid, rdata, busy, m_gnt, m_rv, m_rd, m_busy);
                bad++;
            end
            if (!$onehot0(gnt) || rvalid !== (|gnt) || (gnt & ~prev_req) != 0) begin
                if (inv_bad < 5)
                    $display("FAIL invariant[%0d]: got gnt=%b rv=%b prev_req=%b, want onehot0, rv=|gnt, gnt within req", c, gnt, rvalid, prev_req);
                inv_bad++;
            end
        end
        seed_load = 0; req = 0;
        n_checks++;
        if (bad == 0) n_pass++;
        n_checks++;
        if (inv_bad == 0) n_pass++;
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_single();
                test_round_robin();
                test_reseed();
                test_reset_mid_grant();
                test_period();
                test_random();
            end
            begin
                #200000;
                $display("FAIL timeout: bench did not complete, want completion");
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
